// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch side of the multicycle CPU, driven by the five one-hot
// phase strobes. It owns the PC and IR, fetches at p1, retires at p5 (where it
// applies branch redirects or halts on HLT), and faults on illegal phase patterns.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   p1..p5                phase strobes from the phase counter
//   imem_rdata            instruction memory read data for imem_addr
//   branch_taken/target   redirect request from execute, sampled at p5
//   restart               single-cycle pulse that leaves HALTED
//   imem_addr             instruction fetch address (combinational copy of pc)
//   pc, ir                program counter, instruction register
//   instr_valid           set by the first IR capture after reset
//   halted                high while halted on HLT
//   phase_err             sticky phase-sequence fault
//   retire_count          retired instructions, wraps modulo 2^CNT_W
module fetch_sequencer #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned INSTR_W    = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_MASK  = INSTR_W'(16'hC0F0),
    parameter logic [INSTR_W-1:0] HALT_MATCH = INSTR_W'(16'hC0F0),
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               p1,
    input  logic               p2,
    input  logic               p3,
    input  logic               p4,
    input  logic               p5,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               restart,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               instr_valid,
    output logic               halted,
    output logic               phase_err,
    output logic [CNT_W-1:0]   retire_count
);

    localparam int unsigned PH_W = 5;

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    localparam logic [PH_W-1:0] PH_P1 = 5'b00001;
    localparam logic [PH_W-1:0] PH_P2 = 5'b00010;
    localparam logic [PH_W-1:0] PH_P5 = 5'b10000;

    logic [1:0]         state_q, state_d;
    logic [PH_W-1:0]    exp_q, exp_d;
    logic [ADDR_W-1:0]  pc_d;
    logic [INSTR_W-1:0] ir_d;
    logic               instr_valid_d;
    logic               halted_d;
    logic               phase_err_d;
    logic [CNT_W-1:0]   retire_count_d;

    logic [PH_W-1:0]    ph;
    logic               ph_onehot;
    logic               halt_hit;

    assign ph        = {p5, p4, p3, p2, p1};
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign ph_onehot = (ph != '0) && ((ph & (ph - PH_W'(1))) == '0);
    assign halt_hit  = (ir & HALT_MASK) == HALT_MATCH;
    assign imem_addr = pc;

    // Next-state and register-update logic.
    always_comb begin
        state_d        = state_q;
        exp_d          = exp_q;
        pc_d           = pc;
        ir_d           = ir;
        instr_valid_d  = instr_valid;
        halted_d       = halted;
        phase_err_d    = phase_err;
        retire_count_d = retire_count;

        case (state_q)
            ST_SYNC: begin
                // Only a clean p1 synchronises; anything else is ignored.
                if (ph == PH_P1) begin
                    ir_d          = imem_rdata;
                    pc_d          = pc + ADDR_W'(1);
                    instr_valid_d = 1'b1;
                    state_d       = ST_RUN;
                    exp_d         = PH_P2;
                end
            end
            ST_RUN: begin
                if (!ph_onehot || (ph != exp_q)) begin
                    state_d     = ST_FAULT;
                    phase_err_d = 1'b1;
                end else begin
                    if (ph == PH_P1) begin
                        ir_d          = imem_rdata;
                        pc_d          = pc + ADDR_W'(1);
                        instr_valid_d = 1'b1;
                    end
                    if (ph == PH_P5) begin
                        retire_count_d = retire_count + CNT_W'(1);
                        // HLT wins over a simultaneous branch; pc stays at fetch+1.
                        if (halt_hit) begin
                            state_d  = ST_HALTED;
                            halted_d = 1'b1;
                        end else if (branch_taken) begin
                            pc_d = branch_target;
                        end
                    end
                    exp_d = {exp_q[PH_W-2:0], exp_q[PH_W-1]};
                end
            end
            ST_HALTED: begin
                // Restart only re-arms synchronisation; no fetch this cycle.
                if (restart) begin
                    halted_d = 1'b0;
                    state_d  = ST_SYNC;
                    exp_d    = PH_P1;
                end
            end
            default: begin
                // Fault: everything frozen until reset.
                phase_err_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            exp_q        <= PH_P1;
            pc           <= RESET_PC;
            ir           <= '0;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            phase_err    <= 1'b0;
            retire_count <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            pc           <= pc_d;
            ir           <= ir_d;
            instr_valid  <= instr_valid_d;
            halted       <= halted_d;
            phase_err    <= phase_err_d;
            retire_count <= retire_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an abstract behavioural model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ph_drv;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        restart;
    logic [15:0] imem_rdata;
    logic [15:0] imem_addr;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        instr_valid;
    logic        halted;
    logic        phase_err;
    logic [15:0] retire_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .p1           (ph_drv[0]),
        .p2           (ph_drv[1]),
        .p3           (ph_drv[2]),
        .p4           (ph_drv[3]),
        .p5           (ph_drv[4]),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .restart      (restart),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .ir           (ir),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .phase_err    (phase_err),
        .retire_count (retire_count)
    );

    // Instruction memory: a few fixed words, otherwise a pattern with top bits 00 (never HLT).
    logic [15:0] mem_ovr [logic [15:0]];

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {2'b00, a[13:0] ^ 14'h01A5};
    endfunction

    assign imem_rdata = rd(imem_addr);

    // Model: mode 0=waiting for p1, 1=running, 2=halted, 3=faulted.
    int          m_mode;
    int          m_next;
    logic [15:0] m_pc, m_ir, m_cnt;
    logic        m_valid, m_halted, m_err;

    task automatic m_fetch();
        m_ir    = rd(m_pc);
        m_pc    = m_pc + 16'd1;
        m_valid = 1'b1;
    endtask

    task automatic model_step(input logic [4:0] ph, input logic br, input logic [15:0] tgt,
                              input logic rs, input logic rst);
        int n;
        int idx;
        n   = $countones(ph);
        idx = 0;
        for (int i = 0; i < 5; i++) if (ph[i]) idx = i + 1;
        if (rst) begin
            m_mode = 0; m_next = 1; m_pc = 16'h0000; m_ir = 16'h0000; m_cnt = 16'h0000;
            m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0;
        end else begin
            case (m_mode)
                0: if (n == 1 && idx == 1) begin
                    m_fetch();
                    m_mode = 1;
                    m_next = 2;
                end
                1: if (n != 1 || idx != m_next) begin
                    m_mode = 3;
                    m_err  = 1'b1;
                end else begin
                    if (idx == 1) m_fetch();
                    if (idx == 5) begin
                        m_cnt = m_cnt + 16'd1;
                        if ((m_ir & 16'hC0F0) == 16'hC0F0) begin
                            m_mode   = 2;
                            m_halted = 1'b1;
                        end else if (br) begin
                            m_pc = tgt;
                        end
                    end
                    m_next = (idx == 5) ? 1 : idx + 1;
                end
                2: if (rs) begin
                    m_halted = 1'b0;
                    m_mode   = 0;
                    m_next   = 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        cmp("imem_addr",    32'(imem_addr),    32'(m_pc));
        cmp("pc",           32'(pc),           32'(m_pc));
        cmp("ir",           32'(ir),           32'(m_ir));
        cmp("instr_valid",  32'(instr_valid),  32'(m_valid));
        cmp("halted",       32'(halted),       32'(m_halted));
        cmp("phase_err",    32'(phase_err),    32'(m_err));
        cmp("retire_count", 32'(retire_count), 32'(m_cnt));
    endtask

    // One clock: drive inputs after the falling edge, update model at the rising edge, compare at the next falling edge.
    task automatic tick(input logic [4:0] ph, input logic br = 1'b0, input logic [15:0] tgt = 16'h0,
                        input logic rs = 1'b0, input logic rst = 1'b0);
        ph_drv        = ph;
        branch_taken  = br;
        branch_target = tgt;
        restart       = rs;
        reset         = rst;
        @(posedge clock);
        model_step(ph, br, tgt, rs, rst);
        @(negedge clock);
        compare_all();
    endtask

    task automatic round(input logic br = 1'b0, input logic [15:0] tgt = 16'h0);
        tick(5'b00001);
        tick(5'b00010);
        tick(5'b00100);
        tick(5'b01000);
        tick(5'b10000, br, tgt);
    endtask

    initial begin
        mem_ovr[16'h0000] = 16'h1234;
        mem_ovr[16'h00A0] = 16'h4321;
        mem_ovr[16'h00A1] = 16'hC0F0;
        ph_drv = '0; branch_taken = 1'b0; branch_target = '0; restart = 1'b0; reset = 1'b1;

        tick(5'b00000, 1'b0, 16'h0, 1'b0, 1'b1);
        tick(5'b00000, 1'b0, 16'h0, 1'b0, 1'b1);
        cmp("lit_rst_pc", 32'(pc), 32'h0);
        cmp("lit_rst_ir", 32'(ir), 32'h0);
        cmp("lit_rst_valid", 32'(instr_valid), 32'h0);
        cmp("lit_rst_cnt", 32'(retire_count), 32'h0);

        // Zero and multi-hot are ignored while synchronising.
        tick(5'b00000);
        tick(5'b00011);
        cmp("lit_sync_ign_pc", 32'(pc), 32'h0);
        cmp("lit_sync_ign_err", 32'(phase_err), 32'h0);

        tick(5'b00001);
        cmp("lit_p1_ir", 32'(ir), 32'h1234);
        cmp("lit_p1_pc", 32'(pc), 32'h1);
        cmp("lit_p1_valid", 32'(instr_valid), 32'h1);
        tick(5'b00010); tick(5'b00100); tick(5'b01000); tick(5'b10000);
        cmp("lit_p5_cnt", 32'(retire_count), 32'h1);
        cmp("lit_p5_pc", 32'(pc), 32'h1);

        round(); round();
        cmp("lit_r3_pc", 32'(pc), 32'h3);
        cmp("lit_r3_cnt", 32'(retire_count), 32'h3);
        cmp("lit_r3_err", 32'(phase_err), 32'h0);

        round(1'b1, 16'h00A0);
        cmp("lit_br_pc", 32'(pc), 32'h00A0);
        round();
        cmp("lit_br_ir", 32'(ir), 32'h4321);
        cmp("lit_br_pc2", 32'(pc), 32'h00A1);

        // HLT with a simultaneous branch request.
        round(1'b1, 16'h0055);
        cmp("lit_hlt_halted", 32'(halted), 32'h1);
        cmp("lit_hlt_pc", 32'(pc), 32'h00A2);
        cmp("lit_hlt_cnt", 32'(retire_count), 32'h6);
        for (int i = 0; i < 20; i++) tick(5'b00001 << (i % 5));
        tick(5'b00110);
        cmp("lit_hold_pc", 32'(pc), 32'h00A2);
        cmp("lit_hold_err", 32'(phase_err), 32'h0);
        tick(5'b00001, 1'b0, 16'h0, 1'b1);
        cmp("lit_rs_halted", 32'(halted), 32'h0);
        cmp("lit_rs_pc", 32'(pc), 32'h00A2);
        cmp("lit_rs_ir", 32'(ir), 32'hC0F0);
        round();
        cmp("lit_after_rs_ir", 32'(ir), 32'h0107);
        cmp("lit_after_rs_pc", 32'(pc), 32'h00A3);

        // Skipped phase: p1 then p3.
        tick(5'b00001);
        tick(5'b00100);
        cmp("lit_skip_err", 32'(phase_err), 32'h1);
        tick(5'b00010, 1'b0, 16'h0, 1'b1);
        tick(5'b00001, 1'b1, 16'h1111, 1'b1);
        cmp("lit_fault_pc", 32'(pc), 32'h00A4);
        cmp("lit_fault_cnt", 32'(retire_count), 32'h7);
        tick(5'b00000, 1'b0, 16'h0, 1'b0, 1'b1);
        cmp("lit_clr_err", 32'(phase_err), 32'h0);
        cmp("lit_clr_pc", 32'(pc), 32'h0);

        // Misaligned after reset, then multi-hot in RUN.
        tick(5'b10000);
        tick(5'b00001);
        tick(5'b00110);
        cmp("lit_multi_err", 32'(phase_err), 32'h1);
        tick(5'b01000);

        // Reset mid-round, then resync.
        tick(5'b00000, 1'b0, 16'h0, 1'b0, 1'b1);
        tick(5'b00001);
        tick(5'b00010);
        tick(5'b00000, 1'b0, 16'h0, 1'b0, 1'b1);
        tick(5'b00100);
        round();

        // PC wrap from 16'hFFFF.
        round(1'b1, 16'hFFFF);
        cmp("lit_wrap_pre_pc", 32'(pc), 32'hFFFF);
        tick(5'b00001);
        cmp("lit_wrap_ir", 32'(ir), 32'h3E5A);
        cmp("lit_wrap_pc", 32'(pc), 32'h0);
        cmp("lit_wrap_err", 32'(phase_err), 32'h0);
        tick(5'b00010); tick(5'b00100); tick(5'b01000); tick(5'b10000);
        round();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
